note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler.sv | 99 +++++++++
 tb/tb_note_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: walks a chart ROM and spawns notes into four falling-block slots on their frame.
module note_scheduler #(
  parameter logic [9:0] LANE_X0 = 10'd200,
  parameter logic [9:0] LANE_X1 = 10'd280,
  parameter logic [9:0] LANE_X2 = 10'd360,
  parameter logic [9:0] LANE_X3 = 10'd440
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start,
  output logic [7:0]  chart_addr,
  input  logic [15:0] chart_data,
  input  logic [3:0]  slot_done,
  output logic [3:0]  slot_reset,
  output logic [3:0]  slot_ready,
  output logic [39:0] slot_x,
  output logic        busy,
  output logic        level_done,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SPAWN, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d, drop_q, drop_d;
  logic [12:0] fc_q, fc_d, spawn_q, spawn_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  occ_q, occ_d, rst_q, rst_d, rdy_q, rdy_d;
  logic [39:0] x_q, x_d;
  logic [3:0]  free, grant, rel;
  logic [9:0]  lane_x;
  logic        restart, spawning, active;
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drop_q  <= '0;
      fc_q    <= '0;
      spawn_q <= '0;
      lane_q  <= '0;
      occ_q   <= '0;
      rst_q   <= '0;
      rdy_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      fc_q    <= fc_d;
      spawn_q <= spawn_d;
      lane_q  <= lane_d;
      occ_q   <= occ_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      x_q     <= x_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? FETCH : state_q;
      FETCH:      state_d = (chart_data[15] || addr_q == 8'hFF) ? DRAIN : WAIT;
      WAIT:       state_d = (fc_q >= spawn_q) ? SPAWN : WAIT;
      SPAWN:      state_d = FETCH;
      DRAIN:      state_d = (occ_q == 4'b0000) ? DONE : DRAIN;
      default:    state_d = IDLE;
    endcase
  end
  // release needs ~rst_q so a slot still in its reset pulse ignores a stale done
  always_comb begin
    active   = state_q != IDLE && state_q != DONE;
    restart  = !active && start;
    spawning = state_q == SPAWN;
    free     = ~occ_q;
    grant    = spawning ? (free & (~free + 4'd1)) : 4'b0000;
    rel      = occ_q & rdy_q & slot_done & ~rst_q;
    lane_x   = lane_q == 2'd0 ? LANE_X0 : lane_q == 2'd1 ? LANE_X1 :
               lane_q == 2'd2 ? LANE_X2 : LANE_X3;
    addr_d   = restart ? 8'd0 : spawning ? addr_q + 8'd1 : addr_q;
    fc_d     = restart ? 13'd0 : (active && fc_q != 13'h1FFF) ? fc_q + 13'd1 : fc_q;
    drop_d   = restart ? 8'd0 :
               (spawning && free == 4'b0000 && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    spawn_d  = state_q == FETCH ? chart_data[12:0] : spawn_q;
    lane_d   = state_q == FETCH ? chart_data[14:13] : lane_q;
    occ_d    = (occ_q & ~rel) | grant;
    rst_d    = grant;
    rdy_d    = (rdy_q & ~rel) | rst_q;
  end
  for (genvar i = 0; i < 4; i++) begin : g_x
    assign x_d[10*i +: 10] = grant[i] ? lane_x : x_q[10*i +: 10];
  end
  always_comb begin
    busy       = state_q != IDLE && state_q != DONE;
    level_done = state_q == DONE;
    chart_addr = addr_q;
    drop_cnt   = drop_q;
    slot_reset = rst_q;
    slot_ready = rdy_q;
    slot_x     = x_q;
  end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed scenarios for note_scheduler; cycle k is the state after the k-th edge following start.
module tb_note_scheduler;
  logic        frame_clk = 0;
  logic        Reset = 1;
  logic        start = 0;
  logic [7:0]  chart_addr;
  logic [15:0] chart_data;
  logic [3:0]  slot_done = 0;
  logic [3:0]  slot_reset, slot_ready;
  logic [39:0] slot_x;
  logic        busy, level_done;
  logic [7:0]  drop_cnt;
  logic [15:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  note_scheduler dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .chart_addr(chart_addr),
    .chart_data(chart_data), .slot_done(slot_done), .slot_reset(slot_reset),
    .slot_ready(slot_ready), .slot_x(slot_x), .busy(busy), .level_done(level_done),
    .drop_cnt(drop_cnt)
  );

  assign chart_data = rom[chart_addr];
  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] note(input int lane, input int frame);
    return {1'b0, lane[1:0], frame[12:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic do_reset;
    Reset = 1;
    slot_done = 0;
    start = 0;
    cyc(1);
    Reset = 0;
    cyc(1);
  endtask

  task automatic go;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic test_reset;
    fill_rom(16'h8000);
    do_reset;
    n_cmp++; if (chart_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", chart_addr); end
    n_cmp++; if (slot_reset !== 4'b0 || slot_ready !== 4'b0) begin n_err++; $display("FAIL reset_slots: got rst=%b rdy=%b want 0000/0000", slot_reset, slot_ready); end
    n_cmp++; if (slot_x !== 40'd0) begin n_err++; $display("FAIL reset_x: got %h want 0", slot_x); end
    n_cmp++; if (busy !== 1'b0 || level_done !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_status: got busy=%b done=%b drop=%0d want 0/0/0", busy, level_done, drop_cnt); end
    cyc(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_hold: got busy=%b want 0", busy); end
  endtask

  task automatic test_single_note;
    fill_rom(16'h8000);
    rom[0] = note(1, 5);
    do_reset;
    go;
    cyc(6);
    n_cmp++; if (slot_reset !== 4'b0000) begin n_err++; $display("FAIL single_rst_c6: got %b want 0000", slot_reset); end
    cyc(1);
    n_cmp++; if (slot_reset !== 4'b0001 || slot_ready !== 4'b0000) begin n_err++; $display("FAIL single_rst_c7: got rst=%b rdy=%b want 0001/0000", slot_reset, slot_ready); end
    cyc(1);
    n_cmp++; if (slot_reset !== 4'b0000 || slot_ready !== 4'b0001) begin n_err++; $display("FAIL single_rdy_c8: got rst=%b rdy=%b want 0000/0001", slot_reset, slot_ready); end
    n_cmp++; if (slot_x[9:0] !== 10'd280) begin n_err++; $display("FAIL single_x: got %0d want 280", slot_x[9:0]); end
    slot_done = 4'b0001;
    cyc(1);
    n_cmp++; if (slot_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL single_release: got rdy=%b busy=%b want 0000/1", slot_ready, busy); end
    cyc(1);
    slot_done = 0;
    n_cmp++; if (level_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got done=%b busy=%b want 1/0", level_done, busy); end
    n_cmp++; if (slot_x[9:0] !== 10'd280) begin n_err++; $display("FAIL single_x_hold: got %0d want 280", slot_x[9:0]); end
  endtask

  task automatic test_drop;
    fill_rom(16'h8000);
    for (int i = 0; i < 5; i++) rom[i] = note(i % 4, 0);
    do_reset;
    go;
    for (int k = 0; k < 4; k++) begin
      cyc(3);
      n_cmp++; if (slot_reset !== 4'b0001 << k) begin n_err++; $display("FAIL drop_alloc%0d: got %b want %b", k, slot_reset, 4'b0001 << k); end
    end
    cyc(3);
    n_cmp++; if (drop_cnt !== 8'd1 || slot_reset !== 4'b0000) begin n_err++; $display("FAIL drop_fifth: got drop=%0d rst=%b want 1/0000", drop_cnt, slot_reset); end
    n_cmp++; if (slot_ready !== 4'b1111) begin n_err++; $display("FAIL drop_ready: got %b want 1111", slot_ready); end
    n_cmp++; if (slot_x !== {10'd440, 10'd360, 10'd280, 10'd200}) begin n_err++; $display("FAIL drop_x: got %h want %h", slot_x, {10'd440, 10'd360, 10'd280, 10'd200}); end
    cyc(1);
    n_cmp++; if (busy !== 1'b1 || level_done !== 1'b0) begin n_err++; $display("FAIL drop_drain: got busy=%b done=%b want 1/0", busy, level_done); end
  endtask

  task automatic test_release_reuse;
    fill_rom(16'h8000);
    for (int i = 0; i < 4; i++) rom[i] = note(i, 0);
    rom[4] = note(1, 30);
    do_reset;
    go;
    cyc(15);
    slot_done = 4'b0100;
    cyc(1);
    slot_done = 0;
    n_cmp++; if (slot_ready !== 4'b1011) begin n_err++; $display("FAIL reuse_release: got %b want 1011", slot_ready); end
    cyc(16);
    n_cmp++; if (slot_reset !== 4'b0100) begin n_err++; $display("FAIL reuse_alloc: got %b want 0100", slot_reset); end
    n_cmp++; if (slot_x[29:20] !== 10'd280 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL reuse_x: got x=%0d drop=%0d want 280/0", slot_x[29:20], drop_cnt); end
    cyc(1);
    n_cmp++; if (slot_ready !== 4'b1111) begin n_err++; $display("FAIL reuse_ready: got %b want 1111", slot_ready); end
  endtask

  task automatic test_end_first;
    fill_rom(16'h8000);
    do_reset;
    go;
    n_cmp++; if (busy !== 1'b1 || level_done !== 1'b0) begin n_err++; $display("FAIL endfirst_c0: got busy=%b done=%b want 1/0", busy, level_done); end
    cyc(1);
    n_cmp++; if (busy !== 1'b1 || level_done !== 1'b0) begin n_err++; $display("FAIL endfirst_c1: got busy=%b done=%b want 1/0", busy, level_done); end
    cyc(1);
    n_cmp++; if (level_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL endfirst_c2: got busy=%b done=%b want 0/1", busy, level_done); end
    rom[0] = note(2, 0);
    slot_done = 4'b1111;
    go;
    n_cmp++; if (chart_addr !== 8'd0 || level_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL restart1: got addr=%0d done=%b busy=%b want 0/0/1", chart_addr, level_done, busy); end
    cyc(6);
    n_cmp++; if (level_done !== 1'b1 || chart_addr !== 8'd1) begin n_err++; $display("FAIL restart1_done: got done=%b addr=%0d want 1/1", level_done, chart_addr); end
    n_cmp++; if (slot_x[9:0] !== 10'd360) begin n_err++; $display("FAIL restart1_x: got %0d want 360", slot_x[9:0]); end
    go;
    slot_done = 0;
    n_cmp++; if (chart_addr !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL restart2: got addr=%0d busy=%b want 0/1", chart_addr, busy); end
  endtask

  task automatic test_reset_mid;
    fill_rom(16'h8000);
    rom[0] = note(0, 0);
    rom[1] = note(1, 0);
    rom[2] = note(2, 100);
    do_reset;
    go;
    cyc(8);
    n_cmp++; if (slot_ready !== 4'b0011 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: got rdy=%b busy=%b want 0011/1", slot_ready, busy); end
    Reset = 1;
    #1;
    n_cmp++; if (slot_ready !== 4'b0 || slot_x !== 40'd0 || busy !== 1'b0 || chart_addr !== 8'd0) begin n_err++; $display("FAIL mid_async: got rdy=%b x=%h busy=%b addr=%0d want all 0", slot_ready, slot_x, busy, chart_addr); end
    cyc(1);
    Reset = 0;
    cyc(3);
    n_cmp++; if (busy !== 1'b0 || slot_ready !== 4'b0 || slot_reset !== 4'b0) begin n_err++; $display("FAIL mid_hold: got busy=%b rdy=%b rst=%b want 0/0000/0000", busy, slot_ready, slot_reset); end
    go;
    n_cmp++; if (busy !== 1'b1 || chart_addr !== 8'd0) begin n_err++; $display("FAIL mid_resume: got busy=%b addr=%0d want 1/0", busy, chart_addr); end
  endtask

  task automatic test_no_end;
    fill_rom(note(3, 0));
    do_reset;
    slot_done = 4'b1111;
    go;
    cyc(764);
    n_cmp++; if (chart_addr !== 8'd254) begin n_err++; $display("FAIL noend_c764: got addr=%0d want 254", chart_addr); end
    cyc(1);
    n_cmp++; if (chart_addr !== 8'd255 || busy !== 1'b1) begin n_err++; $display("FAIL noend_c765: got addr=%0d busy=%b want 255/1", chart_addr, busy); end
    cyc(1);
    n_cmp++; if (busy !== 1'b1 || level_done !== 1'b0 || slot_ready !== 4'b0001) begin n_err++; $display("FAIL noend_drain: got busy=%b done=%b rdy=%b want 1/0/0001", busy, level_done, slot_ready); end
    cyc(2);
    n_cmp++; if (level_done !== 1'b1 || chart_addr !== 8'd255 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL noend_done: got done=%b addr=%0d drop=%0d want 1/255/0", level_done, chart_addr, drop_cnt); end
    n_cmp++; if (slot_reset !== 4'b0 || slot_x[9:0] !== 10'd440) begin n_err++; $display("FAIL noend_slots: got rst=%b x=%0d want 0000/440", slot_reset, slot_x[9:0]); end
    slot_done = 0;
  endtask

  initial begin
    test_reset;
    test_single_note;
    test_drop;
    test_release_reuse;
    test_end_first;
    test_reset_mid;
    test_no_end;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
